// File: rtl/bip_control_unit_if.sv
// Bus between the BIP control unit, the program memory and the datapath.
// The "master" modport is the control unit's view; the "slave" modport is
// the environment (program memory plus datapath).
// BIP_CYCLE_COUNT_EN adds the CYCLES counter output to the bundle.
interface bip_control_unit_if #(
  parameter int PC_WIDTH   = 11,
  parameter int DATA_WIDTH = 16
);
  logic                  RUN;
  logic [PC_WIDTH-1:0]   PM_ADDR;
  logic [DATA_WIDTH-1:0] PM_DATA;
  logic [10:0]           OPERAND;
  logic [1:0]            SEL_A;
  logic                  SEL_B;
  logic                  OP;
  logic                  WR_ACC;
  logic                  WR_RAM;
  logic                  RD_RAM;
  logic                  HALTED;
  logic [PC_WIDTH-1:0]   PC;
`ifdef BIP_CYCLE_COUNT_EN
  logic [15:0]           CYCLES;
`endif

  modport master (
    input  RUN, PM_DATA,
    output PM_ADDR, OPERAND, SEL_A, SEL_B, OP, WR_ACC, WR_RAM, RD_RAM,
           HALTED, PC
`ifdef BIP_CYCLE_COUNT_EN
    , output CYCLES
`endif
  );

  modport slave (
    output RUN, PM_DATA,
    input  PM_ADDR, OPERAND, SEL_A, SEL_B, OP, WR_ACC, WR_RAM, RD_RAM,
           HALTED, PC
`ifdef BIP_CYCLE_COUNT_EN
    , input CYCLES
`endif
  );
endinterface

// File: rtl/bip_control_unit.sv
// BIP instruction sequencer: owns the PC, addresses program memory, decodes
// each fetched instruction and strobes accumulator/ALU/data-RAM controls.
// Every instruction takes a FETCH and an EXEC cycle; HLT parks the machine
// in HALT until reset. Strobes are combinational from state and PM_DATA so
// they drop the instant reset is asserted.
// Optional feature macro: BIP_CYCLE_COUNT_EN adds a saturating 16-bit
// CYCLES counter of FETCH/EXEC cycles.
module bip_control_unit #(
  parameter int PC_WIDTH     = 11,
  parameter int DATA_WIDTH   = 16,
  parameter int OPCODE_WIDTH = 5
) (
  input  logic               CLK,
  input  logic               RESET,
  bip_control_unit_if.master bus
);

  localparam int OPERAND_WIDTH = DATA_WIDTH - OPCODE_WIDTH;

  // Opcode map
  localparam logic [OPCODE_WIDTH-1:0] OPC_HLT  = 5'b00000;
  localparam logic [OPCODE_WIDTH-1:0] OPC_STO  = 5'b00001;
  localparam logic [OPCODE_WIDTH-1:0] OPC_LD   = 5'b00010;
  localparam logic [OPCODE_WIDTH-1:0] OPC_LDI  = 5'b00011;
  localparam logic [OPCODE_WIDTH-1:0] OPC_ADD  = 5'b00100;
  localparam logic [OPCODE_WIDTH-1:0] OPC_ADDI = 5'b00101;
  localparam logic [OPCODE_WIDTH-1:0] OPC_SUB  = 5'b00110;
  localparam logic [OPCODE_WIDTH-1:0] OPC_SUBI = 5'b00111;

  // Accumulator source select encodings
  localparam logic [1:0] SEL_A_RAM = 2'd0;
  localparam logic [1:0] SEL_A_IMM = 2'd1;
  localparam logic [1:0] SEL_A_ALU = 2'd2;

  localparam logic [PC_WIDTH-1:0] PC_ONE  = {{(PC_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PC_WIDTH-1:0] PC_ZERO = {PC_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t                   state_r;
  state_t                   state_next_s;
  logic [PC_WIDTH-1:0]      pc_r;
  logic [PC_WIDTH-1:0]      pc_next_s;

  logic [OPCODE_WIDTH-1:0]  opcode_s;
  logic [OPERAND_WIDTH-1:0] operand_s;
  logic [1:0]               sel_a_s;
  logic                     sel_b_s;
  logic                     op_s;
  logic                     wr_acc_s;
  logic                     wr_ram_s;
  logic                     rd_ram_s;

  assign opcode_s = bus.PM_DATA[DATA_WIDTH-1:OPERAND_WIDTH];

  // State and program counter registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r <= ST_IDLE;
      pc_r    <= PC_ZERO;
    end else begin
      state_r <= state_next_s;
      pc_r    <= pc_next_s;
    end
  end

  // Next-state, PC advance and instruction decode; strobes only in EXEC
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    operand_s    = {OPERAND_WIDTH{1'b0}};
    sel_a_s      = SEL_A_RAM;
    sel_b_s      = 1'b0;
    op_s         = 1'b0;
    wr_acc_s     = 1'b0;
    wr_ram_s     = 1'b0;
    rd_ram_s     = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (bus.RUN) begin
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_IDLE;
        end
      end

      ST_FETCH: begin
        // Dropping RUN here abandons the fetch; the PC stays put so the
        // same instruction is fetched again on resume.
        if (bus.RUN) begin
          state_next_s = ST_EXEC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end

      ST_EXEC: begin
        operand_s = bus.PM_DATA[OPERAND_WIDTH-1:0];
        // HLT leaves the PC pointing at itself; everything else advances
        // and wraps naturally at the top of program memory.
        if (opcode_s == OPC_HLT) begin
          state_next_s = ST_HALT;
          pc_next_s    = pc_r;
        end else begin
          state_next_s = ST_FETCH;
          pc_next_s    = pc_r + PC_ONE;
        end

        case (opcode_s)
          OPC_STO: begin
            wr_ram_s = 1'b1;
          end
          OPC_LD: begin
            sel_a_s  = SEL_A_RAM;
            rd_ram_s = 1'b1;
            wr_acc_s = 1'b1;
          end
          OPC_LDI: begin
            sel_a_s  = SEL_A_IMM;
            wr_acc_s = 1'b1;
          end
          OPC_ADD: begin
            sel_a_s  = SEL_A_ALU;
            sel_b_s  = 1'b0;
            op_s     = 1'b0;
            rd_ram_s = 1'b1;
            wr_acc_s = 1'b1;
          end
          OPC_ADDI: begin
            sel_a_s  = SEL_A_ALU;
            sel_b_s  = 1'b1;
            op_s     = 1'b0;
            wr_acc_s = 1'b1;
          end
          OPC_SUB: begin
            sel_a_s  = SEL_A_ALU;
            sel_b_s  = 1'b0;
            op_s     = 1'b1;
            rd_ram_s = 1'b1;
            wr_acc_s = 1'b1;
          end
          OPC_SUBI: begin
            sel_a_s  = SEL_A_ALU;
            sel_b_s  = 1'b1;
            op_s     = 1'b1;
            wr_acc_s = 1'b1;
          end
          default: begin
            // HLT and the unassigned NOP range drive no strobes.
            wr_acc_s = 1'b0;
          end
        endcase
      end

      ST_HALT: begin
        state_next_s = ST_HALT;
      end

      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  assign bus.PM_ADDR = pc_r;
  assign bus.PC      = pc_r;
  assign bus.HALTED  = (state_r == ST_HALT);
  assign bus.OPERAND = operand_s;
  assign bus.SEL_A   = sel_a_s;
  assign bus.SEL_B   = sel_b_s;
  assign bus.OP      = op_s;
  assign bus.WR_ACC  = wr_acc_s;
  assign bus.WR_RAM  = wr_ram_s;
  assign bus.RD_RAM  = rd_ram_s;

`ifdef BIP_CYCLE_COUNT_EN
  logic [15:0] cycles_r;

  // Count FETCH/EXEC cycles, saturating; frozen in IDLE and HALT
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cycles_r <= 16'd0;
    end else if (((state_r == ST_FETCH) || (state_r == ST_EXEC)) &&
                 (cycles_r != 16'hFFFF)) begin
      cycles_r <= cycles_r + 16'd1;
    end else begin
      cycles_r <= cycles_r;
    end
  end

  assign bus.CYCLES = cycles_r;
`endif

endmodule

// File: tb/tb_bip_control_unit.sv
// Self-checking bench for bip_control_unit. A synchronous-read program
// memory model feeds PM_DATA; an instruction-level reference model predicts
// every visible output each cycle.
module tb_bip_control_unit;

  localparam int PCW = 11;
  localparam int DW  = 16;

  logic clk = 1'b0;
  logic reset;

  bip_control_unit_if #(.PC_WIDTH(PCW), .DATA_WIDTH(DW)) bus ();

  bip_control_unit #(
    .PC_WIDTH(PCW), .DATA_WIDTH(DW), .OPCODE_WIDTH(5)
  ) dut (
    .CLK(clk),
    .RESET(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Program memory: one-cycle read latency
  logic [15:0] mem [0:2047];
  always @(posedge clk) bus.PM_DATA <= mem[bus.PM_ADDR];

  int total = 0;
  int bad   = 0;

  // Reference model: 0 stopped, 1 fetching, 2 executing, 3 halted
  int m_mode;
  int m_pc;
  int m_cycle;

  function automatic logic [40:0] obs_vec();
    return {bus.PC, bus.PM_ADDR, bus.HALTED, bus.SEL_A, bus.SEL_B, bus.OP,
            bus.WR_ACC, bus.WR_RAM, bus.RD_RAM, bus.OPERAND};
  endfunction

  // Expected outputs from the instruction table for the current cycle
  function automatic logic [40:0] model_out();
    logic [15:0] ins;
    logic [1:0]  sa;
    logic        sb, op, wa, wr, rr, hl;
    logic [10:0] opd;
    ins = mem[m_pc];
    sa = 2'd0; sb = 1'b0; op = 1'b0; wa = 1'b0; wr = 1'b0; rr = 1'b0;
    opd = 11'd0;
    hl = (m_mode == 3);
    if (m_mode == 2) begin
      opd = ins[10:0];
      case (int'(ins[15:11]))
        1: wr = 1'b1;                                           // STO
        2: begin sa = 2'd0; rr = 1'b1; wa = 1'b1; end           // LD
        3: begin sa = 2'd1; wa = 1'b1; end                      // LDI
        4: begin sa = 2'd2; rr = 1'b1; wa = 1'b1; end           // ADD
        5: begin sa = 2'd2; sb = 1'b1; wa = 1'b1; end           // ADDI
        6: begin sa = 2'd2; op = 1'b1; rr = 1'b1; wa = 1'b1; end // SUB
        7: begin sa = 2'd2; sb = 1'b1; op = 1'b1; wa = 1'b1; end // SUBI
        default: ;
      endcase
    end
    return {11'(m_pc), 11'(m_pc), hl, sa, sb, op, wa, wr, rr, opd};
  endfunction

  task automatic fill_mem(input logic [15:0] v);
    for (int i = 0; i < 2048; i++) mem[i] = v;
  endtask

  task automatic load_prog1();
    for (int i = 0; i < 2048; i++) mem[i] = 16'h4000 | 16'($urandom_range(0, 2047));
    mem[0] = 16'h1805; mem[1] = 16'h2803; mem[2] = 16'h0810; mem[3] = 16'h0000;
  endtask

  // Apply reset for two cycles, release away from the clock edge
  task automatic do_reset();
    bus.RUN = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    m_mode = 0; m_pc = 0; m_cycle = 0;
  endtask

  // One clock: RUN is sampled at the coming edge; model advances with it
  task automatic tick(input logic run);
    bus.RUN = run;
    @(posedge clk);
    case (m_mode)
      0: if (run) m_mode = 1;
      1: m_mode = run ? 2 : 0;
      2: begin
        if (mem[m_pc][15:11] == 5'd0) m_mode = 3;
        else begin m_pc = (m_pc + 1) % 2048; m_mode = 1; end
      end
      default: ;
    endcase
    @(negedge clk);
    m_cycle++;
  endtask

  task automatic test_reset();
    fill_mem(16'h1805);
    bus.RUN = 1'b1;
    reset = 1'b0;
    #3;
    total++;
    if (obs_vec() !== 41'd0) begin
      bad++; $display("FAIL reset_state got=%h exp=%h", obs_vec(), 41'd0);
    end
`ifdef BIP_CYCLE_COUNT_EN
    total++;
    if (bus.CYCLES !== 16'd0) begin
      bad++; $display("FAIL reset_cycles got=%0d exp=0", bus.CYCLES);
    end
`endif
    do_reset();
  endtask

  task automatic test_program();
    logic [40:0] e;
    int n_acc, n_ram, n_rd;
    n_acc = 0; n_ram = 0; n_rd = 0;
    load_prog1();
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      tick(1'b1);
      e = model_out();
      total++;
      if (obs_vec() !== e) begin
        bad++; $display("FAIL prog cyc=%0d got=%h exp=%h", m_cycle, obs_vec(), e);
      end
      n_acc += int'(bus.WR_ACC); n_ram += int'(bus.WR_RAM); n_rd += int'(bus.RD_RAM);
      if (c == 2) begin
        total++;
        if ({bus.WR_ACC, bus.SEL_A, bus.OPERAND} !== {1'b1, 2'd1, 11'd5}) begin
          bad++; $display("FAIL prog_ldi got=%h exp=%h", {bus.WR_ACC, bus.SEL_A, bus.OPERAND}, {1'b1, 2'd1, 11'd5});
        end
      end
      if (c == 4) begin
        total++;
        if ({bus.WR_ACC, bus.SEL_A, bus.SEL_B, bus.OP, bus.OPERAND} !== {1'b1, 2'd2, 1'b1, 1'b0, 11'd3}) begin
          bad++; $display("FAIL prog_addi got=%h exp=%h", {bus.WR_ACC, bus.SEL_A, bus.SEL_B, bus.OP, bus.OPERAND}, {1'b1, 2'd2, 1'b1, 1'b0, 11'd3});
        end
      end
      if (c == 6) begin
        total++;
        if ({bus.WR_RAM, bus.OPERAND} !== {1'b1, 11'h010}) begin
          bad++; $display("FAIL prog_sto got=%h exp=%h", {bus.WR_RAM, bus.OPERAND}, {1'b1, 11'h010});
        end
      end
      if (c == 9) begin
        total++;
        if ({bus.HALTED, bus.PC} !== {1'b1, 11'd3}) begin
          bad++; $display("FAIL prog_halt got=%h exp=%h", {bus.HALTED, bus.PC}, {1'b1, 11'd3});
        end
      end
    end
    total++;
    if (n_acc != 2 || n_ram != 1 || n_rd != 0) begin
      bad++; $display("FAIL prog_pulses got acc=%0d ram=%0d rd=%0d exp acc=2 ram=1 rd=0", n_acc, n_ram, n_rd);
    end
`ifdef BIP_CYCLE_COUNT_EN
    total++;
    if (bus.CYCLES !== 16'd8) begin
      bad++; $display("FAIL cycles_at_halt got=%0d exp=8", bus.CYCLES);
    end
`endif
    for (int c = 0; c < 20; c++) begin
      tick(1'($urandom_range(0, 1)));
      e = model_out();
      total++;
      if (obs_vec() !== e) begin
        bad++; $display("FAIL halt_hold cyc=%0d got=%h exp=%h", m_cycle, obs_vec(), e);
      end
    end
`ifdef BIP_CYCLE_COUNT_EN
    total++;
    if (bus.CYCLES !== 16'd8) begin
      bad++; $display("FAIL cycles_frozen got=%0d exp=8", bus.CYCLES);
    end
`endif
  endtask

  task automatic test_pause();
    logic [40:0] e;
    load_prog1();
    do_reset();
    for (int c = 1; c <= 14; c++) begin
      tick((c >= 4 && c <= 8) ? 1'b0 : 1'b1);
      e = model_out();
      total++;
      if (obs_vec() !== e) begin
        bad++; $display("FAIL pause cyc=%0d got=%h exp=%h", m_cycle, obs_vec(), e);
      end
      if (c >= 4 && c <= 8) begin
        total++;
        if ({bus.PC, bus.WR_ACC, bus.WR_RAM, bus.RD_RAM} !== {11'd1, 3'b000}) begin
          bad++; $display("FAIL pause_idle cyc=%0d got=%h exp=%h", c, {bus.PC, bus.WR_ACC, bus.WR_RAM, bus.RD_RAM}, {11'd1, 3'b000});
        end
      end
      if (c == 10) begin
        total++;
        if ({bus.WR_ACC, bus.SEL_A, bus.SEL_B, bus.OPERAND} !== {1'b1, 2'd2, 1'b1, 11'd3}) begin
          bad++; $display("FAIL pause_resume got=%h exp=%h", {bus.WR_ACC, bus.SEL_A, bus.SEL_B, bus.OPERAND}, {1'b1, 2'd2, 1'b1, 11'd3});
        end
      end
    end
  endtask

  task automatic test_undefined();
    fill_mem(16'h0000);
    mem[0] = 16'hF800;
    do_reset();
    tick(1'b1);
    tick(1'b1);
    total++;
    if ({bus.WR_ACC, bus.WR_RAM, bus.RD_RAM, bus.SEL_A, bus.HALTED} !== 6'd0) begin
      bad++; $display("FAIL undef_exec got=%h exp=0", {bus.WR_ACC, bus.WR_RAM, bus.RD_RAM, bus.SEL_A, bus.HALTED});
    end
    tick(1'b1);
    total++;
    if (bus.PC !== 11'd1) begin
      bad++; $display("FAIL undef_pc got=%0d exp=1", bus.PC);
    end
  endtask

  task automatic test_wrap();
    logic [40:0] e;
    fill_mem(16'hF800);
    do_reset();
    for (int c = 1; c <= 4100; c++) begin
      tick(1'b1);
      e = model_out();
      total++;
      if (obs_vec() !== e) begin
        bad++; $display("FAIL wrap cyc=%0d got=%h exp=%h", m_cycle, obs_vec(), e);
      end
      if (c == 4095) begin
        total++;
        if (bus.PC !== 11'd2047) begin
          bad++; $display("FAIL wrap_top got=%0d exp=2047", bus.PC);
        end
      end
      if (c == 4097) begin
        total++;
        if ({bus.PC, bus.HALTED} !== {11'd0, 1'b0}) begin
          bad++; $display("FAIL wrap_zero got=%h exp=%h", {bus.PC, bus.HALTED}, {11'd0, 1'b0});
        end
      end
    end
  endtask

  task automatic test_reset_exec();
    logic [40:0] e;
    fill_mem(16'hF800);
    mem[0] = 16'h1807;
    mem[1] = 16'h2010;
    do_reset();
    for (int c = 1; c <= 4; c++) tick(1'b1);
    total++;
    if ({bus.WR_ACC, bus.RD_RAM, bus.PC} !== {1'b1, 1'b1, 11'd1}) begin
      bad++; $display("FAIL rst_exec_pre got=%h exp=%h", {bus.WR_ACC, bus.RD_RAM, bus.PC}, {1'b1, 1'b1, 11'd1});
    end
    #1 reset = 1'b0;
    #1;
    total++;
    if ({bus.WR_ACC, bus.RD_RAM, bus.SEL_A, bus.PC} !== {1'b0, 1'b0, 2'd0, 11'd0}) begin
      bad++; $display("FAIL rst_exec_drop got=%h exp=%h", {bus.WR_ACC, bus.RD_RAM, bus.SEL_A, bus.PC}, {1'b0, 1'b0, 2'd0, 11'd0});
    end
    @(negedge clk);
    reset = 1'b1;
    m_mode = 0; m_pc = 0; m_cycle = 0;
    for (int c = 1; c <= 6; c++) begin
      tick((c <= 2) ? 1'b0 : 1'b1);
      e = model_out();
      total++;
      if (obs_vec() !== e) begin
        bad++; $display("FAIL rst_exec_after cyc=%0d got=%h exp=%h", m_cycle, obs_vec(), e);
      end
    end
  endtask

  task automatic test_random();
    logic [40:0] e;
    logic [4:0]  opc;
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 2048; i++) begin
        opc = 5'($urandom_range(0, 31));
        if (opc == 5'd0 && $urandom_range(0, 7) != 0) opc = 5'd4;
        mem[i] = {opc, 11'($urandom_range(0, 2047))};
      end
      do_reset();
      for (int c = 0; c < 150; c++) begin
        tick(1'($urandom_range(0, 3) != 0));
        e = model_out();
        total++;
        if (obs_vec() !== e) begin
          bad++; $display("FAIL random seg=%0d cyc=%0d got=%h exp=%h", s, m_cycle, obs_vec(), e);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.RUN = 1'b0;
    m_mode = 0; m_pc = 0; m_cycle = 0;
    test_reset();
    test_program();
    test_pause();
    test_undefined();
    test_wrap();
    test_reset_exec();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bip_control_unit.md
# bip_control_unit

Instruction sequencer for the BIP processor: owns the program counter, drives the program memory address, decodes each fetched 16-bit instruction and strobes the accumulator/ALU/data-RAM control lines. Sits between the synchronous-read program memory (11-bit address, 16-bit word, one-cycle read latency) and the BIP datapath. Every instruction takes two cycles (FETCH, EXEC). A HLT instruction freezes the machine until reset.

## Interface
- PC_WIDTH, 11, program counter / program memory address width
- DATA_WIDTH, 16, instruction width
- OPCODE_WIDTH, 5, opcode field, instruction bits [15:11]; operand is bits [10:0]
- CLK  in  1  single clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- RUN  in  1  level enable; sampled in IDLE and FETCH
- PM_ADDR  out  PC_WIDTH  program memory address, equals PC
- PM_DATA  in  DATA_WIDTH  program memory read data, valid the cycle after PM_ADDR is presented
- OPERAND  out  11  PM_DATA[10:0] during EXEC, 0 otherwise
- SEL_A  out  2  accumulator source: 0 RAM, 1 immediate, 2 ALU
- SEL_B  out  1  ALU operand B: 0 RAM, 1 immediate
- OP  out  1  ALU op: 0 add, 1 subtract
- WR_ACC  out  1  accumulator write strobe
- WR_RAM  out  1  data RAM write strobe
- RD_RAM  out  1  data RAM read strobe
- HALTED  out  1  high in HALT state
- PC  out  PC_WIDTH  current program counter

## Operation
- States: IDLE, FETCH, EXEC, HALT.
- IDLE: RUN=1 -> FETCH; else stay.
- FETCH: PM_ADDR=PC. RUN=1 -> EXEC; RUN=0 -> IDLE, PC held, no instruction consumed.
- EXEC: decode PM_DATA[15:11]; assert strobes for this cycle only; PC <= PC+1 (mod 2^PC_WIDTH, 2047 -> 0); -> FETCH. Exception: HLT -> HALT, PC not incremented.
- HALT: absorbing; only RESET exits. All strobes 0, HALTED=1.
- Decode (anything not listed is 0):
  - 00000 HLT: no strobes.
  - 00001 STO: WR_RAM.
  - 00010 LD: SEL_A=0, RD_RAM, WR_ACC.
  - 00011 LDI: SEL_A=1, WR_ACC.
  - 00100 ADD: SEL_A=2, SEL_B=0, OP=0, RD_RAM, WR_ACC.
  - 00101 ADDI: SEL_A=2, SEL_B=1, OP=0, WR_ACC.
  - 00110 SUB: as ADD with OP=1.
  - 00111 SUBI: as ADDI with OP=1.
  - 01000–11111: NOP, no strobes, PC increments.
- RUN is ignored in EXEC; an instruction in EXEC always completes.

## Timing
- Reset (async assert): state IDLE, PC=0, PM_ADDR=0, all strobes/SEL/OP/OPERAND=0, HALTED=0. Release is synchronous to the next CLK edge.
- Strobes, SEL_A, SEL_B, OP and OPERAND are combinational from state and PM_DATA, valid only in EXEC.
- RUN=1 held from reset release: FETCH at cycle 1, EXEC at cycle 2; 2 cycles per instruction.
- PC and PM_ADDR update on the EXEC->FETCH edge.
- Reset mid-EXEC: strobes drop immediately; a partially decoded instruction has no effect.

## Configuration
- BIP_CYCLE_COUNT_EN defined: adds output CYCLES [15:0]. It resets to 0 and increments on every edge where the state is FETCH or EXEC. It saturates at 0xFFFF and freezes in HALT and IDLE.
- Undefined: no CYCLES port and no counter logic. All other behaviour is identical.

## Test plan
- Program 0x1805 (LDI 5), 0x2803 (ADDI 3), 0x0810 (STO 0x10), 0x0000 (HLT), RUN=1 -> exactly these pulses, no others:
  - cycle 2: WR_ACC, SEL_A=1, OPERAND=5
  - cycle 4: WR_ACC, SEL_A=2, SEL_B=1, OP=0, OPERAND=3
  - cycle 6: WR_RAM, OPERAND=0x010
  - cycle 9: HALTED=1, with PC=3 held
- Pause: drop RUN in FETCH of instruction 1 for 5 cycles -> IDLE, PC=1, no strobes; restore RUN -> resumes at PC=1 with the correct decode.
- Undefined opcode 0xF800 at address 0 -> EXEC has no strobes, PC=1 afterwards.
- Wrap: memory filled with 0xF800 -> PC goes 2047 -> 0 after 4096 cycles; HALTED stays 0.
- Assert RESET during EXEC of an ADD (0x2010) -> WR_ACC/RD_RAM drop asynchronously; after release PC=0 and state is IDLE.
- BIP_CYCLE_COUNT_EN, first program -> CYCLES=8 at HALT, and still 8 after 20 more cycles.
